// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS main controller: state codes,
// opcode/funct values, ALUOp codes, datapath select codes and instruction classes.
package mc_pkg;

  localparam int STATE_W = 3;
  localparam logic [4:0] RA_REG = 5'd31;

  typedef enum logic [STATE_W-1:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;

  // Bit 3 selects unsigned handling in the downstream ALU control.
  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_SUB   = 4'b0001;
  localparam logic [3:0] ALUOP_FUNCT = 4'b0010;
  localparam logic [3:0] ALUOP_AND   = 4'b0011;
  localparam logic [3:0] ALUOP_SLT   = 4'b0100;
  localparam logic [3:0] ALUOP_ADDU  = 4'b1000;
  localparam logic [3:0] ALUOP_SLTU  = 4'b1100;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

  typedef enum logic [3:0] {
    C_R, C_RSHIFT, C_IALU, C_LW, C_SW, C_BEQ,
    C_J, C_JAL, C_JR, C_JALR, C_ILLEGAL
  } iclass_e;

endpackage

// File: rtl/mc_inst_class_decode.sv
// Combinational decode of OpCode/Funct into an instruction class plus the
// EX-stage ALUOp, extension mode and lui shift flag.
module mc_inst_class_decode
  import mc_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  output iclass_e    iclass,
  output logic [3:0] alu_op,
  output logic       ext_op,
  output logic       lu_op
);

  always_comb begin
    iclass = C_ILLEGAL;
    alu_op = ALUOP_ADD;
    ext_op = 1'b1;
    lu_op  = 1'b0;
    case (op_code)
      OP_RTYPE: begin
        alu_op = ALUOP_FUNCT;
        case (funct)
          F_SLL, F_SRL, F_SRA: iclass = C_RSHIFT;
          F_JR:                iclass = C_JR;
          F_JALR:              iclass = C_JALR;
          default:             iclass = C_R;
        endcase
      end
      OP_J:     iclass = C_J;
      OP_JAL:   iclass = C_JAL;
      OP_BEQ: begin
        iclass = C_BEQ;
        alu_op = ALUOP_SUB;
      end
      OP_LW:    iclass = C_LW;
      OP_SW:    iclass = C_SW;
      OP_ADDI:  iclass = C_IALU;
      OP_ADDIU: begin
        iclass = C_IALU;
        alu_op = ALUOP_ADDU;
      end
      OP_SLTI: begin
        iclass = C_IALU;
        alu_op = ALUOP_SLT;
      end
      OP_SLTIU: begin
        iclass = C_IALU;
        alu_op = ALUOP_SLTU;
      end
      OP_ANDI: begin
        iclass = C_IALU;
        alu_op = ALUOP_AND;
        ext_op = 1'b0;
      end
      OP_LUI: begin
        iclass = C_IALU;
        lu_op  = 1'b1;
      end
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore main controller for the multi-cycle MIPS core: sequences IF/ID/EX/MEM/WB
// and drives the datapath selects and write enables for each state.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               ExtOp,
  output logic               LuOp,
  output logic               InstrDone,
  output logic [STATE_W-1:0] State
);

  state_e     state_q, state_d;
  iclass_e    iclass;
  logic [3:0] dec_alu_op;
  logic       dec_ext_op, dec_lu_op;

  mc_inst_class_decode u_decode (
    .op_code (OpCode),
    .funct   (Funct),
    .iclass  (iclass),
    .alu_op  (dec_alu_op),
    .ext_op  (dec_ext_op),
    .lu_op   (dec_lu_op)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Zero only qualifies PCWriteCond in the datapath; the FSM never branches on it.
  logic unused_zero;
  assign unused_zero = Zero;

  always_comb begin
    state_d     = S_IF;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = RDST_RT;
    MemtoReg    = M2R_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCS_ALU;
    ExtOp       = 1'b0;
    LuOp        = 1'b0;
    InstrDone   = 1'b0;
    State       = '0;
    // Reset masks every output so an aborted instruction leaves no partial write.
    if (!reset) begin
      State = state_q;
      case (state_q)
        S_IF: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
          state_d = S_ID;
        end
        S_ID: begin
          ALUSrcB = SRCB_IMMSH2;
          ExtOp   = 1'b1;
          state_d = S_EX;
          case (iclass)
            C_J, C_JAL: begin
              PCWrite   = 1'b1;
              PCSource  = PCS_JUMP;
              InstrDone = 1'b1;
              state_d   = S_IF;
              if (iclass == C_JAL) begin
                RegWrite = 1'b1;
                RegDst   = RDST_RA;
                MemtoReg = M2R_PC;
              end
            end
            C_JR, C_JALR: begin
              PCWrite   = 1'b1;
              PCSource  = PCS_RS;
              InstrDone = 1'b1;
              state_d   = S_IF;
              if (iclass == C_JALR) begin
                RegWrite = 1'b1;
                RegDst   = RDST_RD;
                MemtoReg = M2R_PC;
              end
            end
            C_ILLEGAL: begin
              InstrDone = 1'b1;
              state_d   = S_IF;
            end
            default: state_d = S_EX;
          endcase
        end
        S_EX: begin
          ALUSrcA = SRCA_RS;
          ALUOp   = dec_alu_op;
          case (iclass)
            C_BEQ: begin
              PCWriteCond = 1'b1;
              PCSource    = PCS_ALUOUT;
              InstrDone   = 1'b1;
              state_d     = S_IF;
            end
            C_LW, C_SW: begin
              ALUSrcB = SRCB_IMM;
              ExtOp   = 1'b1;
              state_d = S_MEM;
            end
            C_R, C_RSHIFT: begin
              if (iclass == C_RSHIFT) ALUSrcA = SRCA_SHAMT;
              state_d = S_WB;
            end
            C_IALU: begin
              ALUSrcB = SRCB_IMM;
              ExtOp   = dec_ext_op;
              LuOp    = dec_lu_op;
              state_d = S_WB;
            end
            default: state_d = S_IF;
          endcase
        end
        S_MEM: begin
          IorD = 1'b1;
          if (iclass == C_SW) begin
            MemWrite  = 1'b1;
            InstrDone = 1'b1;
            state_d   = S_IF;
          end else begin
            MemRead = 1'b1;
            state_d = S_WB;
          end
        end
        S_WB: begin
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
          if (iclass == C_LW) MemtoReg = M2R_MDR;
          else if (iclass == C_R || iclass == C_RSHIFT) RegDst = RDST_RD;
          state_d = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a per-instruction reference of the expected cycle
// sequence is built from the instruction rules and compared every cycle.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OpCode = 6'h23;
  logic [5:0] Funct = 6'h00;
  logic       Zero = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  logic       ExtOp, LuOp, InstrDone;
  logic [2:0] State;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .ExtOp(ExtOp), .LuOp(LuOp), .InstrDone(InstrDone),
    .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, irw, rw;
    logic [1:0] rdst, m2r, srca, srcb;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
    logic ext, lu, done;
    logic [2:0] st;
  } rec_t;

  localparam int K_R = 0, K_SH = 1, K_IALU = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;
  localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_JALR = 9, K_ILL = 10;

  int   errors = 0;
  int   checks = 0;
  rec_t seq[$];
  bit   seq_pld[$];
  rec_t exp_q[$];
  bit   pld_q[$];
  rec_t act;

  assign act = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                 RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp, LuOp,
                 InstrDone, State};

  function automatic int klass(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   return (fn == 6'h08) ? K_JR : (fn == 6'h09) ? K_JALR :
                      (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? K_SH : K_R;
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      6'h04:   return K_BEQ;
      6'h23:   return K_LW;
      6'h2b:   return K_SW;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: return K_IALU;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] ialu_op(input logic [5:0] op);
    case (op)
      6'h09:   return 4'b1000;
      6'h0a:   return 4'b0100;
      6'h0b:   return 4'b1100;
      6'h0c:   return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  // Builds the full expected cycle list of one instruction, plus whether the PC loads.
  task automatic build_seq(input logic [5:0] op, input logic [5:0] fn, input bit z);
    rec_t r;
    int   k;
    k = klass(op, fn);
    seq.delete();
    seq_pld.delete();
    r = '0; r.pcw = 1; r.mrd = 1; r.irw = 1; r.srcb = 2'b01; r.st = 3'd0;
    seq.push_back(r); seq_pld.push_back(1'b1);
    r = '0; r.st = 3'd1; r.srcb = 2'b11; r.ext = 1;
    if (k == K_J || k == K_JAL || k == K_JR || k == K_JALR) begin
      r.pcw = 1; r.done = 1;
      r.pcsrc = (k == K_J || k == K_JAL) ? 2'b10 : 2'b11;
      if (k == K_JAL)  begin r.rw = 1; r.rdst = 2'b10; r.m2r = 2'b10; end
      if (k == K_JALR) begin r.rw = 1; r.rdst = 2'b01; r.m2r = 2'b10; end
      seq.push_back(r); seq_pld.push_back(1'b1);
    end else if (k == K_ILL) begin
      r.done = 1;
      seq.push_back(r); seq_pld.push_back(1'b0);
    end else begin
      seq.push_back(r); seq_pld.push_back(1'b0);
      r = '0; r.st = 3'd2; r.srca = 2'b01;
      if (k == K_BEQ) begin
        r.aluop = 4'b0001; r.pcwc = 1; r.pcsrc = 2'b01; r.done = 1;
        seq.push_back(r); seq_pld.push_back(z);
      end else if (k == K_LW || k == K_SW) begin
        r.srcb = 2'b10; r.ext = 1;
        seq.push_back(r); seq_pld.push_back(1'b0);
        r = '0; r.st = 3'd3; r.iord = 1;
        if (k == K_LW) r.mrd = 1;
        else begin r.mwr = 1; r.done = 1; end
        seq.push_back(r); seq_pld.push_back(1'b0);
      end else begin
        if (k == K_IALU) begin
          r.srcb = 2'b10; r.ext = (op != 6'h0c); r.lu = (op == 6'h0f); r.aluop = ialu_op(op);
        end else begin
          r.aluop = 4'b0010;
          if (k == K_SH) r.srca = 2'b10;
        end
        seq.push_back(r); seq_pld.push_back(1'b0);
      end
      if (k == K_LW || k == K_R || k == K_SH || k == K_IALU) begin
        r = '0; r.st = 3'd4; r.rw = 1; r.done = 1;
        if (k == K_LW) r.m2r = 2'b01;
        if (k == K_R || k == K_SH) r.rdst = 2'b01;
        seq.push_back(r); seq_pld.push_back(1'b0);
      end
    end
  endtask

  task automatic pin(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Plays one instruction; abort_at >= 0 raises reset during that cycle instead.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int abort_at);
    build_seq(op, fn, z);
    OpCode = op; Funct = fn; Zero = z;
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        exp_q.push_back('0); pld_q.push_back(1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        break;
      end
      exp_q.push_back(seq[i]); pld_q.push_back(seq_pld[i]);
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec_t e;
      bit   p;
      logic got_pld;
      e = exp_q.pop_front();
      p = pld_q.pop_front();
      got_pld = PCWrite | (PCWriteCond & Zero);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs op=%h fn=%h: got %h expected %h", OpCode, Funct, act, e);
      end
      checks++;
      if (got_pld !== p) begin
        errors++;
        $display("FAIL pc_load op=%h: got %b expected %b", OpCode, got_pld, p);
      end
    end
  end

  initial begin
    logic [5:0] ops [14];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b,
            6'h0c, 6'h0f, 6'h23, 6'h2b, 6'h3f};
    fns = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20};

    // Pin the reference model with hand-derived values.
    build_seq(6'h23, 6'h00, 1'b0);
    pin("lw_len", seq.size(), 5);
    pin("lw_mem_iord", int'(seq[3].iord), 1);
    pin("lw_wb_m2r", int'(seq[4].m2r), 1);
    build_seq(6'h00, 6'h03, 1'b0);
    pin("sra_len", seq.size(), 4);
    pin("sra_ex_srca", int'(seq[2].srca), 2);
    pin("sra_ex_aluop", int'(seq[2].aluop), 2);
    build_seq(6'h0b, 6'h00, 1'b0);
    pin("sltiu_ex_aluop", int'(seq[2].aluop), 12);
    build_seq(6'h04, 6'h00, 1'b1);
    pin("beq_len", seq.size(), 3);
    build_seq(6'h03, 6'h00, 1'b0);
    pin("jal_len", seq.size(), 2);
    pin("jal_id_rdst", int'(seq[1].rdst), 2);
    build_seq(6'h00, 6'h09, 1'b0);
    pin("jalr_id_pcsrc", int'(seq[1].pcsrc), 3);
    build_seq(6'h3f, 6'h00, 1'b0);
    pin("ill_id_done", int'(seq[1].done) + int'(seq[1].rw), 1);

    // Reset held three cycles with lw on the IR.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('0); pld_q.push_back(1'b0);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    run_instr(6'h23, 6'h00, 1'b0, -1);
    run_instr(6'h00, 6'h03, 1'b0, -1);
    run_instr(6'h0b, 6'h00, 1'b0, -1);
    run_instr(6'h04, 6'h00, 1'b1, -1);
    run_instr(6'h04, 6'h00, 1'b0, -1);
    run_instr(6'h03, 6'h00, 1'b0, -1);
    run_instr(6'h00, 6'h09, 1'b0, -1);
    run_instr(6'h2b, 6'h00, 1'b0, 3);
    run_instr(6'h3f, 6'h00, 1'b0, -1);
    run_instr(6'h0c, 6'h00, 1'b0, -1);
    run_instr(6'h0f, 6'h00, 1'b0, -1);

    for (int n = 0; n < 200; n++) begin
      op = ops[$urandom_range(0, 13)];
      if (op == 6'h3f) op = 6'($urandom_range(0, 63));
      fn = fns[$urandom_range(0, 5)];
      build_seq(op, fn, 1'b0);
      run_instr(op, fn, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, seq.size() - 1)) : -1);
    end

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left unchecked", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Moore-style main controller for the multi-cycle MIPS core.
- Sequences the shared ALU, PC, instruction/data memory port and register file across IF/ID/EX/MEM/WB states.
- Decodes OpCode/Funct from the instruction register into per-state mux selects, write enables and a 4-bit ALUOp. The downstream ALU control block turns ALUOp into ALUCtrl/Sign.
- Sits between the IR and the datapath; replaces the single-cycle combinational control.

Parameters:
- STATE_W, 3, width of state register/debug port
- RA_REG, 5'd31, link register index (reported via RegDst=2'b10; constant held in package)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- OpCode  input  6  IR[31:26], stable from end of IF until next IF
- Funct  input  6  IR[5:0]
- Zero  input  1  ALU zero flag (used only in EX of beq)
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by Zero (datapath ANDs)
- IorD  output  1  0=PC, 1=ALUOut as memory address
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  load IR from memory data
- RegWrite  output  1  register file write enable
- RegDst  output  2  00=rt, 01=rd, 10=$ra
- MemtoReg  output  2  00=ALUOut, 01=MDR, 10=PC (already PC+4)
- ALUSrcA  output  2  00=PC, 01=rs, 10=shamt
- ALUSrcB  output  2  00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
- ALUOp  output  4  [2:0]: 000 add, 001 sub, 010 use Funct, 011 and, 100 slt; [3]: 1=unsigned (addiu, sltiu)
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target, 11=rs
- ExtOp  output  1  1=sign-extend, 0=zero-extend (andi only)
- LuOp  output  1  1=imm<<16 (lui)
- InstrDone  output  1  one-cycle pulse in the last state of each instruction
- State  output  3  current state, for debug

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4. Codes 5-7 are illegal and go to IF with all outputs 0.
- Reset: when reset=1 at a rising edge, State<=IF. While reset is high, all outputs are forced to 0, including IRWrite and PCWrite. The first fetch happens in the first cycle with reset low. Reset mid-instruction aborts it; no partial writes follow.
- IF: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=00, ALUSrcB=01, ALUOp=add, PCSource=00, PCWrite=1 -> ID.
- ID: ALUSrcA=00, ALUSrcB=11, ExtOp=1, ALUOp=add (branch target to ALUOut). Transitions:
  - j: PCWrite=1, PCSource=10, InstrDone -> IF.
  - jal: j actions + RegWrite=1, RegDst=10, MemtoReg=10 -> IF.
  - jr (op 0, funct 08): PCWrite=1, PCSource=11, InstrDone -> IF.
  - jalr (funct 09): jr actions + RegWrite=1, RegDst=01, MemtoReg=10 -> IF.
  - Unsupported opcode: no writes, InstrDone=1 -> IF (nop).
  - Otherwise -> EX.
- EX:
  - beq: ALUSrcA=01, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01, InstrDone -> IF.
  - lw/sw: ALUSrcA=01, ALUSrcB=10, ExtOp=1, add -> MEM.
  - R-type: ALUSrcA=01, or 10 for sll/srl/sra; ALUSrcB=00; ALUOp=010 -> WB.
  - I-ALU (addi/addiu/andi/slti/sltiu/lui): ALUSrcA=01, ALUSrcB=10, ExtOp=0 for andi only, LuOp=1 for lui, ALUOp per class -> WB.
- MEM:
  - lw: MemRead=1, IorD=1 -> WB.
  - sw: MemWrite=1, IorD=1, InstrDone -> IF.
- WB: RegWrite=1, InstrDone=1 -> IF.
  - lw: MemtoReg=01, RegDst=00.
  - R-type: MemtoReg=00, RegDst=01.
  - I-ALU: MemtoReg=00, RegDst=00.
- Any output not listed for a state is 0.
- CPI: j/jal/jr/jalr=2, beq=3, sw/R/I-ALU=4, lw=5.
- OpCode/Funct are sampled combinationally each state. The IR is never rewritten outside IF, so decode is consistent for the whole instruction.
- R-type with funct 08/09 never reaches EX.

Decomposition:
- Package mc_pkg: state codes; opcode/funct constants; ALUOp codes; RegDst/MemtoReg/ALUSrcA/ALUSrcB/PCSource select codes; RA_REG.
- One sub-module, mc_inst_class_decode: combinational OpCode/Funct -> instruction class (R, RSHIFT, IALU, LW, SW, BEQ, J, JAL, JR, JALR, ILLEGAL) plus ALUOp, ExtOp, LuOp.
- FSM register and per-state output logic live in mc_control_fsm.

Test Plan:
- Hold reset 3 cycles with OpCode=0x23. Every output is 0 during reset; the cycle after release, State=0 with MemRead=IRWrite=PCWrite=1 and ALUSrcB=01.
- lw (0x23): State sequence 0,1,2,3,4. MEM shows IorD=1, MemRead=1. WB shows RegWrite=1, MemtoReg=01, RegDst=00, InstrDone=1. Next State=0.
- R-type sra (op 0, funct 03): States 0,1,2,4. EX shows ALUSrcA=10, ALUOp=4'b0010. WB shows RegDst=01. sltiu (0x0b): EX ALUOp=4'b1100.
- beq (0x04) with Zero=1, then with Zero=0: States 0,1,2,0. EX shows PCWriteCond=1, PCSource=01, ALUOp=sub. The datapath PC changes only in the Zero=1 case.
- jal (0x03): States 0,1,0. ID shows PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. jalr (0/09) in ID shows PCSource=11, RegDst=01.
- Assert reset in MEM of sw: MemWrite=0 in that cycle, State=0 next. Opcode 0x3f: ID goes to IF with InstrDone=1 and no write enables asserted.
